// File: rtl/i2s_rx.sv
// I2S receiver: oversamples asynchronous sclk/lrclk/sdata on clk and delivers
// MSB-first, left-justified stereo words with a one-cycle valid strobe.
// Lock is dropped and the receiver re-hunts after TIMEOUT cycles with no sclk
// rising edge.
//
// state | meaning
// ------+------------------------------------------------------------------
// HUNT  | no slot alignment yet; wait for an lrclk change on an sclk rise
// LEFT  | shifting bits of a left slot; commit to holding reg on lrclk change
// RIGHT | shifting bits of a right slot; commit L/R pair on lrclk change
module i2s_rx #(
    parameter int WIDTH   = 16,
    parameter int TIMEOUT = 1024
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             sclk,
    input  logic             lrclk,
    input  logic             sdata,
    output logic [WIDTH-1:0] left_chan,
    output logic [WIDTH-1:0] right_chan,
    output logic             sample_valid,
    output logic             locked,
    output logic             frame_err
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH);
    localparam logic [TW-1:0] TO_LOAD = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_HUNT  = 2'd0,
        ST_LEFT  = 2'd1,
        ST_RIGHT = 2'd2
    } state_t;

    logic [2:0]       sclk_sync_q;
    logic [1:0]       lr_sync_q;
    logic [1:0]       sd_sync_q;

    state_t           state_q;
    logic [WIDTH-1:0] sh_q;
    logic [CW-1:0]    cnt_q;
    logic             lr_prev_q;
    logic             have_left_q;
    logic [WIDTH-1:0] hold_left_q;
    logic [TW-1:0]    to_q;
    logic [WIDTH-1:0] left_q;
    logic [WIDTH-1:0] right_q;
    logic             valid_q;
    logic             locked_q;
    logic             err_q;

    logic             rise;
    logic             lr_s;
    logic             sd_s;
    logic             lr_chg;
    logic [WIDTH-1:0] sh_d;
    logic [CW-1:0]    cnt_d;
    logic             short_slot;

    assign rise   = sclk_sync_q[1] & ~sclk_sync_q[2];
    assign lr_s   = lr_sync_q[1];
    assign sd_s   = sd_sync_q[1];
    assign lr_chg = lr_s ^ lr_prev_q;

    // Two-flop synchronizers; the extra sclk stage gives the rising-edge detect.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sclk_sync_q <= '0;
            lr_sync_q   <= '0;
            sd_sync_q   <= '0;
        end else begin
            sclk_sync_q <= {sclk_sync_q[1:0], sclk};
            lr_sync_q   <= {lr_sync_q[0], lrclk};
            sd_sync_q   <= {sd_sync_q[0], sdata};
        end
    end

    // Slot word with the current bit merged in; the change-edge bit still
    // belongs to the slot being closed, so commits use this merged word.
    always_comb begin
        sh_d  = sh_q;
        cnt_d = cnt_q;
        if (cnt_q < CNT_MAX) begin
            for (int i = 0; i < WIDTH; i++) begin
                if (cnt_q == CW'(WIDTH - 1 - i)) begin
                    sh_d[i] = sd_s;
                end
            end
            cnt_d = cnt_q + CW'(1);
        end
    end

    assign short_slot = (cnt_d < CNT_MAX);

    // Slot FSM, lock/timeout tracking and registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_HUNT;
            sh_q        <= '0;
            cnt_q       <= '0;
            lr_prev_q   <= 1'b0;
            have_left_q <= 1'b0;
            hold_left_q <= '0;
            to_q        <= TO_LOAD;
            left_q      <= '0;
            right_q     <= '0;
            valid_q     <= 1'b0;
            locked_q    <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            if (rise) begin
                to_q      <= TO_LOAD;
                lr_prev_q <= lr_s;
                case (state_q)
                    ST_HUNT: begin
                        if (lr_chg) begin
                            sh_q        <= '0;
                            cnt_q       <= '0;
                            have_left_q <= 1'b0;
                            state_q     <= lr_s ? ST_RIGHT : ST_LEFT;
                        end
                    end
                    ST_LEFT, ST_RIGHT: begin
                        if (lr_chg) begin
                            sh_q  <= '0;
                            cnt_q <= '0;
                            err_q <= short_slot;
                            if (state_q == ST_LEFT) begin
                                hold_left_q <= sh_d;
                                have_left_q <= 1'b1;
                                state_q     <= ST_RIGHT;
                            end else begin
                                if (have_left_q) begin
                                    left_q   <= hold_left_q;
                                    right_q  <= sh_d;
                                    valid_q  <= 1'b1;
                                    locked_q <= 1'b1;
                                end
                                have_left_q <= 1'b0;
                                state_q     <= ST_LEFT;
                            end
                        end else begin
                            sh_q  <= sh_d;
                            cnt_q <= cnt_d;
                        end
                    end
                    default: state_q <= ST_HUNT;
                endcase
            end else if (to_q == '0) begin
                // Held at zero until the next rise; re-entering HUNT is idempotent.
                state_q     <= ST_HUNT;
                locked_q    <= 1'b0;
                have_left_q <= 1'b0;
            end else begin
                to_q <= to_q - TW'(1);
            end
        end
    end

    assign left_chan    = left_q;
    assign right_chan   = right_q;
    assign sample_valid = valid_q;
    assign locked       = locked_q;
    assign frame_err    = err_q;

endmodule

// File: tb/tb_i2s_rx.sv
// Directed bench for i2s_rx: drives I2S frames from clk negedges and checks
// captured pairs, error pulses, latency, lock and timeout behaviour.
module tb_i2s_rx;

    logic        clk;
    logic        reset_n;
    logic        sclk;
    logic        lrclk;
    logic        sdata;
    logic [15:0] left_chan;
    logic [15:0] right_chan;
    logic        sample_valid;
    logic        locked;
    logic        frame_err;

    int n_pass  = 0;
    int n_total = 0;
    int cyc     = 0;
    int last_rise_cyc = 0;

    logic [15:0] vq_l[$];
    logic [15:0] vq_r[$];
    int          vq_cyc[$];
    logic        vq_lock[$];
    int          eq_cyc[$];
    int          lock_fall_cyc = -1;
    logic        locked_prev = 1'b0;
    logic [15:0] prev_l = '0;
    logic [15:0] prev_r = '0;
    logic        chan_glitch = 1'b0;

    i2s_rx #(.WIDTH(16), .TIMEOUT(1024)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .sclk         (sclk),
        .lrclk        (lrclk),
        .sdata        (sdata),
        .left_chan    (left_chan),
        .right_chan   (right_chan),
        .sample_valid (sample_valid),
        .locked       (locked),
        .frame_err    (frame_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Event recorder sampling 1 time unit after each rising edge.
    always begin
        @(posedge clk);
        #1;
        if (sample_valid) begin
            vq_l.push_back(left_chan);
            vq_r.push_back(right_chan);
            vq_cyc.push_back(cyc);
            vq_lock.push_back(locked);
        end
        if (frame_err) eq_cyc.push_back(cyc);
        if (reset_n && locked_prev && !locked) lock_fall_cyc = cyc;
        locked_prev = locked;
        if (reset_n && !sample_valid && (left_chan != prev_l || right_chan != prev_r))
            chan_glitch = 1'b1;
        prev_l = left_chan;
        prev_r = right_chan;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic clear_log();
        vq_l.delete();
        vq_r.delete();
        vq_cyc.delete();
        vq_lock.delete();
        eq_cyc.delete();
    endtask

    task automatic send_bit(input logic lr, input logic d, input int h);
        @(negedge clk);
        sclk  = 1'b0;
        lrclk = lr;
        sdata = d;
        repeat (h) @(negedge clk);
        sclk = 1'b1;
        last_rise_cyc = cyc;
        repeat (h - 1) @(negedge clk);
    endtask

    // Sends bits first..nbits-1 of a left-aligned word; lrclk flips on the last bit.
    task automatic send_slot(input logic lr, input logic [31:0] word, input int first,
                             input int nbits, input int h);
        for (int i = first; i < nbits; i++)
            send_bit((i == nbits - 1) ? ~lr : lr, word[31 - i], h);
    endtask

    task automatic send_frame(input logic [15:0] l, input logic [15:0] r,
                              input int nbits, input int h);
        send_slot(1'b0, {l, 16'h0}, 0, nbits, h);
        send_slot(1'b1, {r, 16'h0}, 0, nbits, h);
    endtask

    task automatic do_reset();
        @(negedge clk);
        sclk = 1'b0;
        @(negedge clk);
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int left_commit;
        logic [31:0] wr;
        sclk    = 1'b0;
        lrclk   = 1'b0;
        sdata   = 1'b0;
        reset_n = 1'b1;

        // Reset values
        @(negedge clk);
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_left", 32'(left_chan), 32'h0);
        check("rst_right", 32'(right_chan), 32'h0);
        check("rst_valid", 32'(sample_valid), 32'h0);
        check("rst_locked", 32'(locked), 32'h0);
        check("rst_err", 32'(frame_err), 32'h0);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        // 32-bit slots, clk:sclk = 32:1
        clear_log();
        send_frame(16'hA5C3, 16'h3C5A, 32, 16);
        check("t1_no_valid_first", 32'(vq_l.size()), 32'd0);
        send_frame(16'hA5C3, 16'h3C5A, 32, 16);
        check("t1_nvalid", 32'(vq_l.size()), 32'd1);
        if (vq_l.size() > 0) begin
            check("t1_left", 32'(vq_l[0]), 32'hA5C3);
            check("t1_right", 32'(vq_r[0]), 32'h3C5A);
            check("t1_locked", 32'(vq_lock[0]), 32'h1);
            check("t1_latency", 32'(vq_cyc[0] - last_rise_cyc), 32'd3);
        end
        check("t1_nerr", 32'(eq_cyc.size()), 32'd0);

        // Exact 16-bit slots, three frames
        clear_log();
        send_frame(16'h1111, 16'h2222, 16, 4);
        send_frame(16'h3333, 16'h4444, 16, 4);
        send_frame(16'h8000, 16'h7FFF, 16, 4);
        check("t2_nvalid", 32'(vq_l.size()), 32'd3);
        if (vq_l.size() == 3) begin
            check("t2_l0", 32'(vq_l[0]), 32'h1111);
            check("t2_r0", 32'(vq_r[0]), 32'h2222);
            check("t2_l1", 32'(vq_l[1]), 32'h3333);
            check("t2_r1", 32'(vq_r[1]), 32'h4444);
            check("t2_l2", 32'(vq_l[2]), 32'h8000);
            check("t2_r2", 32'(vq_r[2]), 32'h7FFF);
        end
        check("t2_nerr", 32'(eq_cyc.size()), 32'd0);

        // Short 12-bit left slot
        clear_log();
        send_slot(1'b0, {12'hABC, 20'h0}, 0, 12, 4);
        left_commit = last_rise_cyc;
        send_slot(1'b1, {16'h1234, 16'h0}, 0, 16, 4);
        check("t3_nerr", 32'(eq_cyc.size()), 32'd1);
        if (eq_cyc.size() > 0) check("t3_err_cycle", 32'(eq_cyc[0] - left_commit), 32'd3);
        check("t3_nvalid", 32'(vq_l.size()), 32'd1);
        if (vq_l.size() > 0) begin
            check("t3_left", 32'(vq_l[0]), 32'hABC0);
            check("t3_right", 32'(vq_r[0]), 32'h1234);
        end

        // Stream starting mid right slot
        lrclk = 1'b1;
        do_reset();
        clear_log();
        send_slot(1'b1, {16'h7777, 16'h0}, 8, 16, 4);
        check("t4_no_valid_partial", 32'(vq_l.size()), 32'd0);
        send_frame(16'h5555, 16'h6666, 16, 4);
        check("t4_nvalid", 32'(vq_l.size()), 32'd1);
        if (vq_l.size() > 0) begin
            check("t4_left", 32'(vq_l[0]), 32'h5555);
            check("t4_right", 32'(vq_r[0]), 32'h6666);
        end

        // sclk stopped: lock timeout
        clear_log();
        lock_fall_cyc = -1;
        @(negedge clk);
        sclk = 1'b0;
        repeat (1100) @(negedge clk);
        check("t5_lock_fall_cycle", 32'(lock_fall_cyc - last_rise_cyc), 32'd1027);
        check("t5_locked", 32'(locked), 32'h0);
        check("t5_left_held", 32'(left_chan), 32'h5555);
        check("t5_right_held", 32'(right_chan), 32'h6666);
        send_frame(16'h9999, 16'hAAAA, 16, 4);
        check("t5_no_valid_rehunt", 32'(vq_l.size()), 32'd0);
        send_frame(16'hBBBB, 16'hCCCC, 16, 4);
        check("t5_nvalid", 32'(vq_l.size()), 32'd1);
        if (vq_l.size() > 0) begin
            check("t5_left", 32'(vq_l[0]), 32'hBBBB);
            check("t5_right", 32'(vq_r[0]), 32'hCCCC);
            check("t5_relocked", 32'(vq_lock[0]), 32'h1);
        end

        // Reset during bit 7 of a right slot
        clear_log();
        wr = {16'hEEEE, 16'h0};
        send_slot(1'b0, {16'hDDDD, 16'h0}, 0, 16, 8);
        for (int i = 0; i < 7; i++) send_bit(1'b1, wr[31 - i], 8);
        @(negedge clk);
        sclk  = 1'b0;
        lrclk = 1'b1;
        sdata = wr[31 - 7];
        repeat (2) @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("t6_rst_left", 32'(left_chan), 32'h0);
        check("t6_rst_right", 32'(right_chan), 32'h0);
        check("t6_rst_valid", 32'(sample_valid), 32'h0);
        check("t6_rst_locked", 32'(locked), 32'h0);
        check("t6_rst_err", 32'(frame_err), 32'h0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        sclk = 1'b1;
        last_rise_cyc = cyc;
        repeat (7) @(negedge clk);
        send_slot(1'b1, wr, 8, 16, 8);
        check("t6_no_valid_partial", 32'(vq_l.size()), 32'd0);
        check("t6_left_zero", 32'(left_chan), 32'h0);
        send_frame(16'h1357, 16'h2468, 16, 8);
        check("t6_nvalid", 32'(vq_l.size()), 32'd1);
        if (vq_l.size() > 0) begin
            check("t6_left", 32'(vq_l[0]), 32'h1357);
            check("t6_right", 32'(vq_r[0]), 32'h2468);
        end

        check("chan_stable_between_valid", 32'(chan_glitch), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
